lcd_char_render: RTL and testbench
==================================

LCD_CHAR_RENDER -- requirements
Module: lcd_char_render

Interface
REQ-001 Parameter FG_COLOR, 16'h0000, RGB565 colour for font bit = 1.
REQ-002 Parameter BG_COLOR, 16'hFFFF, RGB565 colour for font bit = 0.
REQ-003 Parameter CHAR_TOTAL, 67, number of characters per screen refresh.
REQ-004 Parameter GAP_CYCLES, 3, idle cycles between show_char_done and latching the next character's inputs.
REQ-005 sys_clk  in  1  clock; all logic on its rising edge.
REQ-006 sys_rst_n  in  1  reset, asynchronous, active-low.
REQ-007 show_char_flag  in  1  one-cycle pulse; starts a screen refresh.
REQ-008 ascii_num  in  7  font index (ASCII minus 32).
REQ-009 start_x  in  9  top-left column of the character cell.
REQ-010 start_y  in  9  top-left row of the character cell.
REQ-011 en_size  in  1  font select: 1 = 16x8, 0 = 12x6.
REQ-012 show_char_done  out  1  one-cycle pulse when a character is fully emitted.
REQ-013 pix_valid  out  1  pixel write request.
REQ-014 pix_ready  in  1  LCD write stage accepts the pixel.
REQ-015 pix_x  out  9  pixel column.
REQ-016 pix_y  out  9  pixel row.
REQ-017 pix_color  out  16  pixel colour.
REQ-018 busy  out  1  high in every state except IDLE.

Function
REQ-019 The FSM SHALL have the states IDLE, GAP, FETCH, DRAW and DONE.
REQ-020 IDLE: show_char_flag SHALL clear char_cnt and enter GAP; a flag seen in any other state SHALL be ignored.
REQ-021 GAP: the block SHALL wait GAP_CYCLES cycles, latch ascii_num, start_x, start_y and en_size on the last cycle, set row=0, then enter FETCH.
REQ-022 FETCH: the block SHALL present ROM address {size, ascii, row[3:0]} and enter DRAW next cycle (ROM latency exactly 1).
REQ-023 DRAW: pix_valid SHALL be 1 with col starting at 0; col SHALL advance only on pix_valid && pix_ready.
REQ-024 pix_x, pix_y and pix_color SHALL hold stable while pix_valid && !pix_ready.
REQ-025 Pixel geometry: pix_x = start_x + col and pix_y = start_y + row, 9-bit modulo (wrap, no clipping).
REQ-026 Pixel colour: pix_color = FG_COLOR if rom_row[7-col] else BG_COLOR; 12x6 glyphs are MSB-aligned in the 8-bit ROM row.
REQ-027 Cell size: width W = 8 and height H = 16 when the latched size = 1; W = 6 and H = 12 otherwise.
REQ-028 On the handshake of col = W-1: if row < H-1, the block SHALL increment row and return to FETCH; otherwise it SHALL enter DONE.
REQ-029 pix_valid SHALL be 0 outside DRAW.
REQ-030 DONE: show_char_done SHALL be 1 for exactly one cycle and char_cnt SHALL increment; the next state SHALL be IDLE if the new char_cnt = CHAR_TOTAL, else GAP.
REQ-031 Latency: the first pix_valid SHALL occur exactly GAP_CYCLES+2 cycles after show_char_flag is sampled.
REQ-032 Throughput: with pix_ready held at 1, a 16x8 character SHALL take 144 cycles from FETCH of row 0 to DONE (16 x (1+8)).
REQ-033 char_cnt SHALL be 7 bits and SHALL saturate by returning to IDLE, never wrapping.

Reset
REQ-034 On sys_rst_n low, the block SHALL asynchronously enter IDLE with row=0, col=0, char_cnt=0, all latched inputs 0, pix_valid=0, show_char_done=0, busy=0, pix_x=0, pix_y=0 and pix_color=BG_COLOR.
REQ-035 Reset asserted mid-character SHALL abandon the character without emitting show_char_done; after release the block SHALL wait for a new show_char_flag.

Structure
REQ-036 A shared package SHALL hold the FSM state encoding, the font dimensions (8/16, 6/12) and the RGB565 colour constants.
REQ-037 The font SHALL live in one sub-module, char_font_rom: synchronous read, 1-cycle latency, address {size, ascii[6:0], row[3:0]}, 8-bit data.

Verification
REQ-038 Flag pulse, ascii_num=88 ('x'), start (56,0), en_size=1, pix_ready=1 -> 128 pixels with x 56..63 and y 0..15 in row-major order; show_char_done 1 cycle after the last pixel; first pix_valid 5 cycles after the flag.
REQ-039 en_size=0, start (0,16) -> 72 pixels with x 0..5 and y 16..27; colours match ROM bits [7:2].
REQ-040 pix_ready toggling pseudo-randomly -> no pixel lost or duplicated and outputs stable while stalled; total handshakes = 128.
REQ-041 CHAR_TOTAL=3, inputs updated 2 cycles after each done -> exactly 3 done pulses, each char uses the inputs present at its latch cycle, then IDLE with busy=0.
REQ-042 start_x=508, en_size=1 -> pix_x sequence 508..511, 0..3 (wrap).
REQ-043 Reset asserted at pixel 40 -> all outputs at reset values, no done pulse; new flag -> full character rendered correctly.

Source files
------------

// File: rtl/lcd_char_render_pkg.sv
// Shared definitions for the LCD character renderer: FSM encoding, font cell
// dimensions, RGB565 colour constants and cell-size helpers.
package lcd_char_render_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GAP,
    ST_FETCH,
    ST_DRAW,
    ST_DONE
  } state_t;

  localparam int FONT_W_BIG   = 8;
  localparam int FONT_H_BIG   = 16;
  localparam int FONT_W_SMALL = 6;
  localparam int FONT_H_SMALL = 12;

  localparam logic [15:0] RGB565_BLACK = 16'h0000;
  localparam logic [15:0] RGB565_WHITE = 16'hFFFF;

  function automatic logic [2:0] last_col(input logic big);
    return big ? 3'(FONT_W_BIG - 1) : 3'(FONT_W_SMALL - 1);
  endfunction

  function automatic logic [3:0] last_row(input logic big);
    return big ? 4'(FONT_H_BIG - 1) : 4'(FONT_H_SMALL - 1);
  endfunction

endpackage

// File: rtl/lcd_char_render_font_rom.sv
// Glyph ROM, one registered read per cycle: address {size, ascii, row}, 8-bit row data.
// Small glyphs are MSB-aligned; glyphs without a drawn shape render as a hollow box.
module char_font_rom
  import lcd_char_render_pkg::*;
(
  input  logic        sys_clk,
  input  logic [11:0] addr,
  output logic [7:0]  data
);

  logic       big;
  logic [6:0] ascii;
  logic [3:0] row;
  logic [7:0] glyph;

  assign {big, ascii, row} = addr;

  always_comb begin
    glyph = 8'h00;
    if (ascii == 7'd88) begin
      if (big) begin
        case (row)
          4'd6, 4'd14:         glyph = 8'hE7;
          4'd7, 4'd13:         glyph = 8'h42;
          4'd8, 4'd12:         glyph = 8'h24;
          4'd9, 4'd10, 4'd11:  glyph = 8'h18;
          default:             glyph = 8'h00;
        endcase
      end else begin
        case (row)
          4'd4, 4'd9:  glyph = 8'hD8;
          4'd5, 4'd8:  glyph = 8'h50;
          4'd6, 4'd7:  glyph = 8'h20;
          default:     glyph = 8'h00;
        endcase
      end
    end else if (big) begin
      glyph = (row == 4'd0 || row == 4'(FONT_H_BIG - 1)) ? 8'hFF : 8'h81;
    end else begin
      glyph = (row == 4'd0 || row == 4'(FONT_H_SMALL - 1)) ? 8'hFC : 8'h84;
    end
  end

  always_ff @(posedge sys_clk) begin
    data <= glyph;
  end

endmodule

// File: rtl/lcd_char_render.sv
// Renders CHAR_TOTAL font cells per refresh as a valid/ready pixel stream;
// first pixel GAP_CYCLES+2 cycles after the flag, pixels held stable while stalled.
module lcd_char_render
  import lcd_char_render_pkg::*;
#(
  parameter logic [15:0] FG_COLOR   = RGB565_BLACK,
  parameter logic [15:0] BG_COLOR   = RGB565_WHITE,
  parameter int          CHAR_TOTAL = 67,
  parameter int          GAP_CYCLES = 3
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        show_char_flag,
  input  logic [6:0]  ascii_num,
  input  logic [8:0]  start_x,
  input  logic [8:0]  start_y,
  input  logic        en_size,
  output logic        show_char_done,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [8:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic [15:0] pix_color,
  output logic        busy
);

  state_t      state;
  logic [7:0]  gap_cnt;
  logic [6:0]  char_cnt;
  logic [6:0]  char_cnt_nxt;
  logic [3:0]  row;
  logic [2:0]  col;
  logic [6:0]  ascii_q;
  logic [8:0]  x_q;
  logic [8:0]  y_q;
  logic        size_q;
  logic [11:0] rom_addr;
  logic [7:0]  rom_row;

  assign rom_addr = {size_q, ascii_q, row};

  char_font_rom u_font_rom (
    .sys_clk (sys_clk),
    .addr    (rom_addr),
    .data    (rom_row)
  );

  // rom_row and col only change on an accepted pixel, so these stay put under a stall.
  assign char_cnt_nxt = char_cnt + 7'd1;
  assign pix_x        = x_q + {6'd0, col};
  assign pix_y        = y_q + {5'd0, row};
  assign pix_color    = (pix_valid && rom_row[3'd7 - col]) ? FG_COLOR : BG_COLOR;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state          <= ST_IDLE;
      gap_cnt        <= 8'd0;
      char_cnt       <= 7'd0;
      row            <= 4'd0;
      col            <= 3'd0;
      ascii_q        <= 7'd0;
      x_q            <= 9'd0;
      y_q            <= 9'd0;
      size_q         <= 1'b0;
      pix_valid      <= 1'b0;
      show_char_done <= 1'b0;
      busy           <= 1'b0;
    end else begin
      show_char_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (show_char_flag) begin
            char_cnt <= 7'd0;
            gap_cnt  <= 8'd0;
            busy     <= 1'b1;
            state    <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt == 8'(GAP_CYCLES - 1)) begin
            ascii_q <= ascii_num;
            x_q     <= start_x;
            y_q     <= start_y;
            size_q  <= en_size;
            row     <= 4'd0;
            col     <= 3'd0;
            state   <= ST_FETCH;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        ST_FETCH: begin
          pix_valid <= 1'b1;
          state     <= ST_DRAW;
        end
        ST_DRAW: begin
          if (pix_valid && pix_ready) begin
            if (col == last_col(size_q)) begin
              col       <= 3'd0;
              pix_valid <= 1'b0;
              if (row == last_row(size_q)) begin
                show_char_done <= 1'b1;
                state          <= ST_DONE;
              end else begin
                row   <= row + 4'd1;
                state <= ST_FETCH;
              end
            end else begin
              col <= col + 3'd1;
            end
          end
        end
        ST_DONE: begin
          char_cnt <= char_cnt_nxt;
          gap_cnt  <= 8'd0;
          if (char_cnt_nxt == 7'(CHAR_TOTAL)) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            state <= ST_GAP;
          end
        end
        default: begin
          pix_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_char_render.sv
// Directed bench for lcd_char_render: table of character vectors checked pixel by pixel
// against hand-written glyph tables, plus input-update and mid-character reset sequences.
module tb_lcd_char_render;

  localparam logic [15:0] FG  = 16'hF800;
  localparam logic [15:0] BG  = 16'h07E0;
  localparam int          GAP = 3;
  localparam int          NCH = 3;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        show_char_flag;
  logic [6:0]  ascii_num;
  logic [8:0]  start_x;
  logic [8:0]  start_y;
  logic        en_size;
  logic        show_char_done;
  logic        pix_valid;
  logic        pix_ready;
  logic [8:0]  pix_x;
  logic [8:0]  pix_y;
  logic [15:0] pix_color;
  logic        busy;

  lcd_char_render #(
    .FG_COLOR   (FG),
    .BG_COLOR   (BG),
    .CHAR_TOTAL (NCH),
    .GAP_CYCLES (GAP)
  ) dut (
    .sys_clk        (sys_clk),
    .sys_rst_n      (sys_rst_n),
    .show_char_flag (show_char_flag),
    .ascii_num      (ascii_num),
    .start_x        (start_x),
    .start_y        (start_y),
    .en_size        (en_size),
    .show_char_done (show_char_done),
    .pix_valid      (pix_valid),
    .pix_ready      (pix_ready),
    .pix_x          (pix_x),
    .pix_y          (pix_y),
    .pix_color      (pix_color),
    .busy           (busy)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [8:0]  x;
    logic [8:0]  y;
    logic [15:0] c;
  } pix_t;

  typedef struct {
    int ascii;
    int sx;
    int sy;
    bit big;
    bit rnd;
    int npix;
    int fx;
    int fy;
    int lx;
    int ly;
  } vec_t;

  vec_t vecs[4];
  pix_t got_q[$];
  pix_t exp_q[$];
  int   done_at[$];

  int   total = 0;
  int   bad = 0;
  int   tick_n = 0;
  int   last_hs = -10;
  int   done_late = 0;
  int   stall_err = 0;
  int   stall_n = 0;
  bit   rnd_ready = 0;
  bit   was_stall = 0;
  pix_t held;
  logic [15:0] lfsr = 16'hACE1;

  task automatic check(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  // One cycle: sample outputs at the falling edge, then choose pix_ready for the next rising edge.
  task automatic tick();
    @(negedge sys_clk);
    tick_n++;
    if (was_stall) begin
      if (!pix_valid || pix_x !== held.x || pix_y !== held.y || pix_color !== held.c)
        stall_err++;
    end
    if (show_char_done) begin
      done_at.push_back(got_q.size());
      if (last_hs != tick_n - 1) done_late++;
    end
    if (rnd_ready) begin
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      pix_ready = lfsr[0];
    end else begin
      pix_ready = 1'b1;
    end
    was_stall = pix_valid && !pix_ready;
    if (was_stall) begin
      stall_n++;
      held = {pix_x, pix_y, pix_color};
    end
    if (pix_valid && pix_ready) begin
      got_q.push_back({pix_x, pix_y, pix_color});
      last_hs = tick_n;
    end
  endtask

  function automatic logic [7:0] glyph(input int ascii, input bit big, input int row);
    if (ascii == 88) begin
      if (big) begin
        case (row)
          6, 14:     return 8'hE7;
          7, 13:     return 8'h42;
          8, 12:     return 8'h24;
          9, 10, 11: return 8'h18;
          default:   return 8'h00;
        endcase
      end else begin
        case (row)
          4, 9:    return 8'hD8;
          5, 8:    return 8'h50;
          6, 7:    return 8'h20;
          default: return 8'h00;
        endcase
      end
    end
    if (big) return (row == 0 || row == 15) ? 8'hFF : 8'h81;
    return (row == 0 || row == 11) ? 8'hFC : 8'h84;
  endfunction

  task automatic add_char(input int ascii, input int sx, input int sy, input bit big);
    int w;
    int h;
    logic [7:0] g;
    pix_t p;
    w = big ? 8 : 6;
    h = big ? 16 : 12;
    for (int r = 0; r < h; r++) begin
      g = glyph(ascii, big, r);
      for (int c = 0; c < w; c++) begin
        p.x = 9'((sx + c) % 512);
        p.y = 9'((sy + r) % 512);
        p.c = g[7 - c] ? FG : BG;
        exp_q.push_back(p);
      end
    end
  endtask

  task automatic check_pixels(input string tag);
    int nbad;
    nbad = 0;
    check({tag, " pixel count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      if (got_q[i] !== exp_q[i]) begin
        if (nbad == 0)
          $display("  %s first bad pixel %0d: got x=%0d y=%0d c=%h, expected x=%0d y=%0d c=%h",
                   tag, i, got_q[i].x, got_q[i].y, got_q[i].c, exp_q[i].x, exp_q[i].y, exp_q[i].c);
        nbad++;
      end
    end
    check({tag, " pixel mismatches"}, nbad, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " pix_valid"}, int'(pix_valid), 0);
    check({tag, " show_char_done"}, int'(show_char_done), 0);
    check({tag, " busy"}, int'(busy), 0);
    check({tag, " pix_x"}, int'(pix_x), 0);
    check({tag, " pix_y"}, int'(pix_y), 0);
    check({tag, " pix_color"}, int'(pix_color), int'(BG));
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check({tag, " reached idle"}, int'(busy), 0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    got_q.delete();
    exp_q.delete();
    done_at.delete();
    done_late = 0;
    stall_err = 0;
    stall_n = 0;
    rnd_ready = v.rnd;
    ascii_num = 7'(v.ascii);
    start_x = 9'(v.sx);
    start_y = 9'(v.sy);
    en_size = v.big;
    for (int k = 0; k < NCH; k++) add_char(v.ascii, v.sx, v.sy, v.big);
    tick();
    show_char_flag = 1'b1;
    lat = 0;
    do begin
      tick();
      show_char_flag = 1'b0;
      lat++;
    end while (!pix_valid && lat < 40);
    check({tag, " first valid latency"}, lat, GAP + 2);
    wait_idle(8000, tag);
    check({tag, " done pulses"}, done_at.size(), NCH);
    for (int k = 0; k < done_at.size(); k++)
      check($sformatf("%s done %0d position", tag, k), done_at[k], v.npix * (k + 1));
    check({tag, " done timing"}, done_late, 0);
    if (got_q.size() >= v.npix) begin
      check({tag, " first x"}, int'(got_q[0].x), v.fx);
      check({tag, " first y"}, int'(got_q[0].y), v.fy);
      check({tag, " last x"}, int'(got_q[v.npix - 1].x), v.lx);
      check({tag, " last y"}, int'(got_q[v.npix - 1].y), v.ly);
    end
    check_pixels(tag);
    if (v.rnd) begin
      check({tag, " stall stability"}, stall_err, 0);
      check({tag, " stalls exercised"}, int'(stall_n > 20), 1);
    end
    rnd_ready = 0;
  endtask

  initial begin
    int sa[3];
    int sxs[3];
    int sys[3];
    bit sbs[3];
    int seen;
    int chg;
    int n;
    bit pulsed;

    sys_rst_n = 1'b0;
    show_char_flag = 1'b0;
    ascii_num = 7'd0;
    start_x = 9'd0;
    start_y = 9'd0;
    en_size = 1'b0;
    pix_ready = 1'b1;

    //           ascii  sx   sy  big rnd npix  fx   fy   lx   ly
    vecs[0] = '{ 88,    56,  0,  1,  0,  128,  56,  0,   63,  15 };
    vecs[1] = '{ 88,    0,   16, 0,  0,  72,   0,   16,  5,   27 };
    vecs[2] = '{ 33,    100, 200,1,  1,  128,  100, 200, 107, 215};
    vecs[3] = '{ 88,    508, 500,1,  0,  128,  508, 500, 3,   3  };

    repeat (3) @(negedge sys_clk);
    check_reset_outputs("reset");
    sys_rst_n = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 4; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Inputs change two cycles after each done; a stray flag mid-refresh must be ignored.
    sa  = '{88, 5, 88};
    sxs = '{10, 300, 0};
    sys = '{20, 40, 100};
    sbs = '{1'b1, 1'b0, 1'b0};
    got_q.delete();
    exp_q.delete();
    done_at.delete();
    done_late = 0;
    for (int k = 0; k < NCH; k++) add_char(sa[k], sxs[k], sys[k], sbs[k]);
    ascii_num = 7'(sa[0]);
    start_x = 9'(sxs[0]);
    start_y = 9'(sys[0]);
    en_size = sbs[0];
    tick();
    show_char_flag = 1'b1;
    seen = 0;
    chg = -1;
    n = 0;
    pulsed = 0;
    do begin
      tick();
      n++;
      show_char_flag = 1'b0;
      if (done_at.size() != seen) begin
        seen = done_at.size();
        chg = tick_n + 2;
      end
      if (tick_n == chg && seen < NCH) begin
        ascii_num = 7'(sa[seen]);
        start_x = 9'(sxs[seen]);
        start_y = 9'(sys[seen]);
        en_size = sbs[seen];
      end
      if (!pulsed && got_q.size() == 20) begin
        show_char_flag = 1'b1;
        pulsed = 1;
      end
    end while ((busy === 1'b1 || seen < NCH) && n < 3000);
    check("update seq done pulses", done_at.size(), NCH);
    check("update seq done timing", done_late, 0);
    check_pixels("update seq");
    repeat (6) tick();
    check("update seq busy after end", int'(busy), 0);
    check("update seq no extra pixels", got_q.size(), exp_q.size());

    // Reset partway through a character, then render a fresh refresh.
    got_q.delete();
    done_at.delete();
    ascii_num = 7'd88;
    start_x = 9'd56;
    start_y = 9'd0;
    en_size = 1'b1;
    tick();
    show_char_flag = 1'b1;
    tick();
    show_char_flag = 1'b0;
    n = 0;
    while (got_q.size() < 40 && n < 500) begin
      tick();
      n++;
    end
    check("mid reset reached pixel 40", got_q.size(), 40);
    sys_rst_n = 1'b0;
    was_stall = 0;
    #1;
    check_reset_outputs("mid reset");
    repeat (3) tick();
    sys_rst_n = 1'b1;
    repeat (12) tick();
    check("mid reset no done", done_at.size(), 0);
    check("mid reset stays idle", int'(busy), 0);
    check("mid reset no pixels after reset", got_q.size(), 40);
    run_vec(vecs[0], "after reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
